// File: rtl/fmm_reduce_row_swap_if.sv
// Block-level handshake, argument and M_e BRAM bus for fmm_reduce_row_swap.
// The master side is the caller and owns the BRAM read data; the slave side is the swap stage.
interface fmm_reduce_row_swap_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [31:0]       pivot_row;
  logic [30:0]       target_row;
  logic [8:0]        ncols;
  logic [ADDR_W-1:0] base_off;
  logic [ADDR_W-1:0] M_e_address0;
  logic              M_e_ce0;
  logic              M_e_we0;
  logic [DATA_W-1:0] M_e_d0;
  logic [DATA_W-1:0] M_e_q0;
  logic              swapped;
  logic              swapped_ap_vld;

  modport master (
    output ap_start, pivot_row, target_row, ncols, base_off, M_e_q0,
    input  ap_done, ap_idle, ap_ready, M_e_address0, M_e_ce0, M_e_we0, M_e_d0,
    input  swapped, swapped_ap_vld
  );

  modport slave (
    input  ap_start, pivot_row, target_row, ncols, base_off, M_e_q0,
    output ap_done, ap_idle, ap_ready, M_e_address0, M_e_ce0, M_e_we0, M_e_d0,
    output swapped, swapped_ap_vld
  );
endinterface

// File: rtl/fmm_reduce_row_swap.sv
// Exchanges the pivot row with the target row of M_e in a single-port BRAM.
// Optional FMM_ROW_SWAP_COUNT_EN adds a saturating swap counter with synchronous clear.
module fmm_reduce_row_swap #(
  parameter int ROW_STRIDE = 320,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
`ifdef FMM_ROW_SWAP_COUNT_EN
  input  logic        swap_count_clr,
  output logic [31:0] swap_count,
`endif
  fmm_reduce_row_swap_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RDP,
    S_RDT,
    S_WRP,
    S_WRT,
    S_DONE
  } state_t;

  state_t            state;
  logic [31:0]       pivot_r;
  logic [30:0]       target_r;
  logic [8:0]        ncols_r;
  logic [ADDR_W-1:0] base_r;
  logic [8:0]        col;
  logic [DATA_W-1:0] tmp_p;
  logic [ADDR_W-1:0] addr_r;
  logic              ce_r;
  logic              we_r;
  logic [DATA_W-1:0] d0_r;
  logic              done_r;
  logic              swapped_r;

  logic [ADDR_W-1:0] pbase;
  logic [ADDR_W-1:0] tbase;
  logic [8:0]        col_inc;
  logic [ADDR_W-1:0] pa_cur;
  logic [ADDR_W-1:0] ta_cur;
  logic [ADDR_W-1:0] pa_inc;
  logic              do_swap;

  function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] r);
    if (ROW_STRIDE == 320) return (r << 8) + (r << 6);
    else                   return r * ADDR_W'(ROW_STRIDE);
  endfunction

  // Row bases are taken modulo 2^ADDR_W, so oversized rows or offsets wrap silently.
  assign pbase   = row_base(pivot_r[ADDR_W-1:0]) + base_r;
  assign tbase   = row_base(target_r[ADDR_W-1:0]) + base_r;
  assign col_inc = col + 9'd1;
  assign pa_cur  = pbase + ADDR_W'(col);
  assign ta_cur  = tbase + ADDR_W'(col);
  assign pa_inc  = pbase + ADDR_W'(col_inc);
  assign do_swap = !pivot_r[31] && (pivot_r != {1'b0, target_r}) && (ncols_r != '0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      pivot_r   <= '0;
      target_r  <= '0;
      ncols_r   <= '0;
      base_r    <= '0;
      col       <= '0;
      tmp_p     <= '0;
      addr_r    <= '0;
      ce_r      <= 1'b0;
      we_r      <= 1'b0;
      d0_r      <= '0;
      done_r    <= 1'b0;
      swapped_r <= 1'b0;
    end else begin
      ce_r   <= 1'b0;
      we_r   <= 1'b0;
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            pivot_r  <= bus.pivot_row;
            target_r <= bus.target_row;
            ncols_r  <= bus.ncols;
            base_r   <= bus.base_off;
            col      <= '0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (do_swap) begin
            swapped_r <= 1'b1;
            ce_r      <= 1'b1;
            addr_r    <= pa_cur;
            state     <= S_RDP;
          end else begin
            swapped_r <= 1'b0;
            done_r    <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RDP: begin
          ce_r   <= 1'b1;
          addr_r <= ta_cur;
          state  <= S_RDT;
        end
        S_RDT: begin
          tmp_p  <= bus.M_e_q0;
          ce_r   <= 1'b1;
          we_r   <= 1'b1;
          addr_r <= pa_cur;
          state  <= S_WRP;
        end
        S_WRP: begin
          ce_r   <= 1'b1;
          we_r   <= 1'b1;
          addr_r <= ta_cur;
          d0_r   <= tmp_p;
          state  <= S_WRT;
        end
        S_WRT: begin
          if (col_inc == ncols_r) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else begin
            col    <= col_inc;
            ce_r   <= 1'b1;
            addr_r <= pa_inc;
            state  <= S_RDP;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The target word arrives on q0 during the pivot write, so d0 bypasses the register there.
  assign bus.M_e_d0         = (state == S_WRP) ? bus.M_e_q0 : d0_r;
  assign bus.M_e_address0   = addr_r;
  assign bus.M_e_ce0        = ce_r;
  assign bus.M_e_we0        = we_r;
  assign bus.ap_done        = done_r;
  assign bus.ap_ready       = done_r;
  assign bus.swapped_ap_vld = done_r;
  assign bus.swapped        = swapped_r;
  assign bus.ap_idle        = (state == S_IDLE) && !bus.ap_start;

`ifdef FMM_ROW_SWAP_COUNT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      swap_count <= '0;
    end else if (swap_count_clr) begin
      swap_count <= '0;
    end else if (done_r && swapped_r && (swap_count != '1)) begin
      swap_count <= swap_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fmm_reduce_row_swap.sv
// Self-checking bench for fmm_reduce_row_swap: BRAM model, latency/flag and memory scoreboards.
module tb_fmm_reduce_row_swap;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  fmm_reduce_row_swap_if #(.ADDR_W(17), .DATA_W(32)) bus ();

`ifdef FMM_ROW_SWAP_COUNT_EN
  logic        swap_count_clr = 1'b0;
  logic [31:0] swap_count;
`endif

  fmm_reduce_row_swap #(.ROW_STRIDE(320), .ADDR_W(17), .DATA_W(32)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
`ifdef FMM_ROW_SWAP_COUNT_EN
    .swap_count_clr (swap_count_clr),
    .swap_count     (swap_count),
`endif
    .bus            (bus)
  );

  typedef struct { int lat; logic sw; int ce; int we; } exp_t;
  typedef struct { logic [16:0] a; logic [31:0] d; } mem_exp_t;

  exp_t     exp_q[$];
  mem_exp_t mem_q[$];
  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:131071];
  logic        bd_we   = 1'b0;
  logic [16:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int ce_cnt = 0;
  int we_cnt = 0;

  always @(posedge ap_clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.M_e_ce0) begin
      if (bus.M_e_we0) mem[bus.M_e_address0] <= bus.M_e_d0;
      else             bus.M_e_q0 <= mem[bus.M_e_address0];
    end
  end

  always @(posedge ap_clk) begin
    if (bus.M_e_ce0 === 1'b1) ce_cnt <= ce_cnt + 1;
    if (bus.M_e_we0 === 1'b1) we_cnt <= we_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] row_addr(input logic [31:0] r, input logic [16:0] b, input int c);
    logic [31:0] s;
    s = r * 32'd320 + {15'd0, b} + 32'(c);
    return s[16:0];
  endfunction

  task automatic poke(input logic [16:0] a, input logic [31:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge ap_clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic fill(input logic [16:0] a, input int cnt, input logic [31:0] seed);
    for (int i = 0; i < cnt; i++) poke(a + 17'(i), seed ^ (32'(i) * 32'h0001_0003));
  endtask

  task automatic push_swap(input logic [31:0] p, input logic [30:0] t, input logic [8:0] n,
                           input logic [16:0] b);
    for (int c = 0; c < int'(n); c++) begin
      mem_exp_t x;
      logic [16:0] pa, ta;
      pa = row_addr(p, b, c);
      ta = row_addr({1'b0, t}, b, c);
      x.a = pa; x.d = mem[ta]; mem_q.push_back(x);
      x.a = ta; x.d = mem[pa]; mem_q.push_back(x);
    end
  endtask

  task automatic check_mem();
    mem_exp_t x;
    while (mem_q.size() > 0) begin
      x = mem_q.pop_front();
      n_cmp++;
      if (mem[x.a] !== x.d) begin
        n_err++;
        $display("FAIL mem[%0d]: got %h expected %h", x.a, mem[x.a], x.d);
      end
    end
  endtask

  task automatic do_run(input logic [31:0] p, input logic [30:0] t, input logic [8:0] n,
                        input logic [16:0] b);
    exp_t e, g;
    int k, ce0, we0;
    e.sw  = !p[31] && (p != {1'b0, t}) && (n != 9'd0);
    e.lat = e.sw ? 4 * int'(n) + 2 : 2;
    e.ce  = e.sw ? 4 * int'(n) : 0;
    e.we  = e.sw ? 2 * int'(n) : 0;
    exp_q.push_back(e);
    if (e.sw) push_swap(p, t, n, b);
    bus.pivot_row = p; bus.target_row = t; bus.ncols = n; bus.base_off = b;
    bus.ap_start = 1'b1;
    ce0 = ce_cnt; we0 = we_cnt;
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    bus.pivot_row = ~p; bus.target_row = ~t; bus.ncols = n ^ 9'h0AA; bus.base_off = ~b;
    k = 1;
    while (bus.ap_done !== 1'b1 && k < 2000) begin
      @(posedge ap_clk); #1;
      k++;
    end
    g.lat = k; g.sw = bus.swapped; g.ce = ce_cnt - ce0; g.we = we_cnt - we0;
    e = exp_q.pop_front();
    n_cmp++;
    if (g.lat !== e.lat) begin
      n_err++; $display("FAIL latency p=%0d t=%0d n=%0d: got %0d expected %0d", p, t, n, g.lat, e.lat);
    end
    n_cmp++;
    if ({g.sw, bus.swapped_ap_vld, bus.ap_ready} !== {e.sw, 2'b11}) begin
      n_err++; $display("FAIL swapped/vld/ready: got %b%b%b expected %b11", g.sw,
                        bus.swapped_ap_vld, bus.ap_ready, e.sw);
    end
    n_cmp++;
    if (g.ce !== e.ce || g.we !== e.we) begin
      n_err++; $display("FAIL bram_access: got ce=%0d we=%0d expected ce=%0d we=%0d", g.ce, g.we, e.ce, e.we);
    end
    @(posedge ap_clk); #1;
    n_cmp++;
    if ({bus.ap_done, bus.ap_idle} !== 2'b01) begin
      n_err++; $display("FAIL done_pulse: got done=%b idle=%b expected done=0 idle=1", bus.ap_done, bus.ap_idle);
    end
    check_mem();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ap_clk);
    #1;
    n_cmp++;
    if ({bus.ap_done, bus.ap_ready, bus.M_e_ce0, bus.M_e_we0, bus.swapped, bus.swapped_ap_vld,
         bus.M_e_address0, bus.ap_idle} !== {6'b0, 17'd0, 1'b1}) begin
      n_err++; $display("FAIL reset_outputs: got done=%b ce=%b we=%b addr=%0d idle=%b expected 0 0 0 0 1",
                        bus.ap_done, bus.M_e_ce0, bus.M_e_we0, bus.M_e_address0, bus.ap_idle);
    end
    bus.ap_start = 1'b1; #1;
    n_cmp++;
    if (bus.ap_idle !== 1'b0) begin
      n_err++; $display("FAIL idle_follows_start: got %b expected 0", bus.ap_idle);
    end
    bus.ap_start = 1'b0;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    n_cmp++;
    if (bus.ap_idle !== 1'b1) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 1", bus.ap_idle);
    end
  endtask

  task automatic test_basic_swap();
    for (int i = 0; i < 4; i++) begin
      poke(17'(960 + i), 32'(i + 1));
      poke(17'(i), 32'(9 - i));
    end
    do_run(32'd3, 31'd0, 9'd4, 17'd0);
    n_cmp++;
    if ({mem[0], mem[3], mem[960], mem[963]} !== {32'd1, 32'd4, 32'd9, 32'd6}) begin
      n_err++; $display("FAIL basic_values: got %0d %0d %0d %0d expected 1 4 9 6",
                        mem[0], mem[3], mem[960], mem[963]);
    end
  endtask

  task automatic test_no_pivot();
    do_run(32'hFFFF_FFFF, 31'd2, 9'd10, 17'd0);
  endtask

  task automatic test_same_row();
    do_run(32'd5, 31'd5, 9'd320, 17'd0);
  endtask

  task automatic test_zero_cols();
    do_run(32'd6, 31'd9, 9'd0, 17'd0);
  endtask

  task automatic test_full_row();
    mem_exp_t x;
    fill(17'd326, 642, 32'hA5A5_0000);
    x.a = 17'd326; x.d = mem[326]; mem_q.push_back(x);
    x.a = 17'd967; x.d = mem[967]; mem_q.push_back(x);
    do_run(32'd1, 31'd2, 9'd320, 17'd7);
  endtask

  task automatic test_wrap();
    fill(17'h1FFFE, 5, 32'h1234_5600);
    fill(17'd510, 5, 32'hCAFE_0000);
    do_run(32'd409, 31'd1, 9'd5, 17'd190);
  endtask

  task automatic test_back_to_back();
    int k;
    fill(17'd6400, 1, 32'h0000_BEEF);
    fill(17'd6720, 1, 32'h0000_F00D);
    push_swap(32'd20, 31'd21, 9'd1, 17'd0);
    bus.pivot_row = 32'd20; bus.target_row = 31'd21; bus.ncols = 9'd1; bus.base_off = 17'd0;
    bus.ap_start = 1'b1;
    @(posedge ap_clk); #1;
    k = 1;
    while (bus.ap_done !== 1'b1 && k < 100) begin @(posedge ap_clk); #1; k++; end
    n_cmp++;
    if (k !== 6 || bus.swapped !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: got lat=%0d sw=%b expected lat=6 sw=1", k, bus.swapped);
    end
    bus.pivot_row = 32'd30; bus.target_row = 31'd30; bus.ncols = 9'd5;
    k = 0;
    while (k < 100) begin
      @(posedge ap_clk); #1; k++;
      if (bus.ap_done === 1'b1) break;
    end
    n_cmp++;
    if (k !== 3 || bus.swapped !== 1'b0) begin
      n_err++; $display("FAIL b2b_second: got edges=%0d sw=%b expected edges=3 sw=0", k, bus.swapped);
    end
    bus.ap_start = 1'b0;
    @(posedge ap_clk); #1;
    check_mem();
  endtask

  task automatic test_reset_mid();
    int k, we_snap;
    mem_exp_t x;
    logic [16:0] pa2, ta2;
    fill(17'd3200, 8, 32'h1111_0000);
    fill(17'd3520, 8, 32'h2222_0000);
    for (int c = 0; c < 8; c++) begin
      x.a = row_addr(32'd10, 17'd0, c); x.d = (c < 2) ? mem[row_addr(32'd11, 17'd0, c)] : mem[x.a];
      mem_q.push_back(x);
      x.a = row_addr(32'd11, 17'd0, c); x.d = (c < 2) ? mem[row_addr(32'd10, 17'd0, c)] : mem[x.a];
      mem_q.push_back(x);
    end
    pa2 = row_addr(32'd10, 17'd0, 2);
    ta2 = row_addr(32'd11, 17'd0, 2);
    bus.pivot_row = 32'd10; bus.target_row = 31'd11; bus.ncols = 9'd8; bus.base_off = 17'd0;
    bus.ap_start = 1'b1;
    @(posedge ap_clk); #1;
    bus.ap_start = 1'b0;
    k = 1;
    while (k < 12) begin @(posedge ap_clk); #1; k++; end
    n_cmp++;
    if ({bus.M_e_we0, bus.M_e_address0, bus.M_e_d0} !== {1'b1, pa2, mem[ta2]}) begin
      n_err++; $display("FAIL wrp_col2: got we=%b addr=%0d d0=%h expected we=1 addr=%0d d0=%h",
                        bus.M_e_we0, bus.M_e_address0, bus.M_e_d0, pa2, mem[ta2]);
    end
    #2 ap_rst_n = 1'b0;
    #1;
    we_snap = we_cnt;
    n_cmp++;
    if ({bus.ap_done, bus.ap_ready, bus.M_e_ce0, bus.M_e_we0, bus.swapped, bus.swapped_ap_vld,
         bus.M_e_address0, bus.ap_idle} !== {6'b0, 17'd0, 1'b1}) begin
      n_err++; $display("FAIL mid_reset_outputs: got ce=%b we=%b addr=%0d idle=%b expected 0 0 0 1",
                        bus.M_e_ce0, bus.M_e_we0, bus.M_e_address0, bus.ap_idle);
    end
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (6) @(posedge ap_clk);
    #1;
    n_cmp++;
    if (we_cnt !== we_snap) begin
      n_err++; $display("FAIL we_after_reset: got %0d writes expected 0", we_cnt - we_snap);
    end
    check_mem();
    do_run(32'd10, 31'd11, 9'd8, 17'd0);
  endtask

`ifdef FMM_ROW_SWAP_COUNT_EN
  task automatic test_swap_count();
    swap_count_clr = 1'b1;
    @(posedge ap_clk); #1;
    swap_count_clr = 1'b0;
    n_cmp++;
    if (swap_count !== 32'd0) begin
      n_err++; $display("FAIL count_clear0: got %0d expected 0", swap_count);
    end
    fill(17'd12800, 2, 32'h3333_0000);
    fill(17'd13120, 2, 32'h4444_0000);
    for (int r = 0; r < 3; r++) do_run(32'd40, 31'd41, 9'd2, 17'd0);
    do_run(32'hFFFF_FFFF, 31'd41, 9'd2, 17'd0);
    n_cmp++;
    if (swap_count !== 32'd3) begin
      n_err++; $display("FAIL count_value: got %0d expected 3", swap_count);
    end
    swap_count_clr = 1'b1;
    @(posedge ap_clk); #1;
    swap_count_clr = 1'b0;
    n_cmp++;
    if (swap_count !== 32'd0) begin
      n_err++; $display("FAIL count_clear: got %0d expected 0", swap_count);
    end
  endtask
`endif

  initial begin
    bus.ap_start   = 1'b0;
    bus.pivot_row  = '0;
    bus.target_row = '0;
    bus.ncols      = '0;
    bus.base_off   = '0;
    test_reset();
    test_basic_swap();
    test_no_pivot();
    test_same_row();
    test_zero_cols();
    test_full_row();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef FMM_ROW_SWAP_COUNT_EN
    test_swap_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
